hex_digit_scanner: RTL and testbench
====================================

// Module: hex_digit_scanner
// PURPOSE
//  Time-multiplexed scan controller for a DIGITS-wide common-cathode 7-segment display.
//  Holds a frame-synchronous copy of the display value and walks the digits at a fixed rate.
//  Each slot presents one nibble plus its dp bit to the downstream single-digit hex decoder,
//  and drives the matching digit-select line. Sits directly upstream of the decoder.
// PARAMETERS
//  DIGITS         4      number of digits; digit 0 is least significant (>=2)
//  PRESCALE       50000  CLK cycles per digit slot (>=2)
//  BLANK_CYCLES   2      anti-ghost guard at the start of each slot, all SEL inactive (< PRESCALE)
//  SEL_ACTIVE_LOW 1      1: selected digit drives SEL bit 0; 0: drives 1
// PORTS
//  CLK         in   1          clock, all logic rising-edge
//  RST         in   1          synchronous reset, active-high
//  HEX_data    in   4*DIGITS   nibble k at [4k+3:4k]
//  dp_data     in   DIGITS     decimal point per digit
//  load        in   1          capture HEX_data/dp_data this cycle
//  lz_blank    in   1          enable leading-zero suppression
//  HEX_out     out  4          nibble for current slot, to decoder HEX_in
//  dp_out      out  1          dp for current slot, to decoder dp_in
//  blank_out   out  1          1 = decoder output must be forced blank
//  SEL         out  DIGITS     digit enables, one active at most
//  pending     out  1          captured value waiting for frame boundary
//  scan_tick   out  1          1-cycle pulse on every slot advance
//  frame_done  out  1          1-cycle pulse when slot DIGITS-1 advances to slot 0
// BEHAVIOUR
//  - Reset (sync, priority over all):
//    prescaler=0; idx=0; active and pending regs=0; pending=0; SEL all inactive.
//    HEX_out=0; dp_out=0; blank_out=1; scan_tick=0; frame_done=0.
//    A load asserted together with RST is dropped.
//  - Prescaler counts 0..PRESCALE-1 and wraps. On its terminal count (tc):
//    idx advances, wrapping from DIGITS-1 to 0.
//  - scan_tick is registered: high for the one cycle following the edge that advances idx.
//    frame_done is high in that same cycle when idx became 0.
//  - Outputs are registered and computed from the idx/prescaler values after each edge.
//    HEX_out, dp_out and blank_out change on the same edge as idx.
//  - SEL: all inactive while prescaler < BLANK_CYCLES. Otherwise SEL[idx] is the only
//    active bit, with polarity per SEL_ACTIVE_LOW.
//  - Load handshake (tear-free):
//    - load without a frame boundary: HEX_data/dp_data go to the pending regs; pending=1.
//      A later load overwrites pending data (last wins).
//    - frame boundary (tc with idx==DIGITS-1) with pending=1: active <= pending regs; pending=0.
//    - load on the same cycle as a frame boundary: HEX_data/dp_data go straight to active
//      and pending=0. The older pending data is discarded.
//    - New active data is first visible in slot 0 of the new frame.
//  - Leading-zero suppression (lz_blank=1): digit k>0 is blanked when every active nibble
//    from DIGITS-1 down to k is 0 and no dp bit from DIGITS-1 down to k is set.
//    - Digit 0 is never blanked.
//    - A blanked slot gives blank_out=1 and dp_out=0; SEL still scans normally.
//    - lz_blank=0: blank_out=0 outside reset.
//  - Reset mid-scan restarts at slot 0 with the guard interval and clears pending data.
// TESTING (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, SEL_ACTIVE_LOW=1)
//  1 Hold RST 3 cycles then release
//    -> SEL=4'b1111, blank_out=1 during reset.
//    -> Slot 0 runs 4 cycles: 1 cycle SEL=1111, then 3 cycles SEL=1110.
//    -> Slot order 0,1,2,3,0; scan_tick every 4 cycles; frame_done on the 3->0 advance only.
//  2 load with HEX_data=16'h1234 in mid-frame
//    -> pending=1; HEX_out keeps old values until frame end.
//    -> Next frame shows 4,3,2,1 in slots 0..3; pending=0 from the boundary edge.
//  3 Two loads in one frame (16'hAAAA, then 16'h5555)
//    -> Next frame shows 5 in every slot; 'A' is never displayed.
//  4 load 16'hBEEF on the exact frame-boundary cycle while 16'h1111 is pending
//    -> Next frame shows F,E,E,B; pending=0; 1 is never displayed.
//  5 lz_blank=1, HEX_data=16'h0070, dp_data=0
//    -> Slots 3,2 give blank_out=1; slot 1 gives HEX_out=7; slot 0 gives HEX_out=0, blank_out=0.
//    -> Repeat with dp_data=4'b0100: slot 2 unblanked with dp_out=1; slot 3 still blanked.
//  6 Assert RST for 1 cycle at slot 2 with pending=1
//    -> Reset values on the next cycle; pending data is lost.
//    -> Scan restarts at slot 0 showing 0.

Source files
------------

// File: rtl/hex_digit_scanner.sv
// Multiplexed 7-segment scan controller: walks DIGITS slots, feeds one nibble/dp to the decoder,
// double-buffers the display value so updates only take effect on a frame boundary.
module hex_digit_scanner #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   HEX_data,
    input  logic [DIGITS-1:0]     dp_data,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [3:0]            HEX_out,
    output logic                  dp_out,
    output logic                  blank_out,
    output logic [DIGITS-1:0]     SEL,
    output logic                  pending,
    output logic                  scan_tick,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_act_hex;
    logic [DIGITS-1:0]     r_act_dp;
    logic [4*DIGITS-1:0]   r_pend_hex;
    logic [DIGITS-1:0]     r_pend_dp;

    logic                  w_tc;
    logic                  w_frame;
    logic [PW-1:0]         w_presc_n;
    logic [IW-1:0]         w_idx_n;
    logic [4*DIGITS-1:0]   w_hex_n;
    logic [DIGITS-1:0]     w_dp_n;
    logic [DIGITS-1:0]     w_lz;
    logic [DIGITS-1:0]     w_sel_n;
    logic [3:0]            w_nib;
    logic                  w_nib_dp;
    logic                  w_nib_blank;

    always_comb begin
        w_tc      = (r_presc == PRESC_MAX);
        w_frame   = w_tc && (r_idx == IDX_MAX);
        w_presc_n = w_tc ? '0 : r_presc + 1'b1;
        w_idx_n   = r_idx;
        if (w_tc) begin
            w_idx_n = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end

        // A load landing on the boundary cycle wins over whatever was pending.
        w_hex_n = r_act_hex;
        w_dp_n  = r_act_dp;
        if (w_frame) begin
            if (load) begin
                w_hex_n = HEX_data;
                w_dp_n  = dp_data;
            end else if (pending) begin
                w_hex_n = r_pend_hex;
                w_dp_n  = r_pend_dp;
            end
        end

        // w_lz[k]: every digit from the top down to k is a plain zero without dp.
        w_lz = '0;
        w_lz[DIGITS-1] = (w_hex_n[4*(DIGITS-1) +: 4] == 4'h0) && !w_dp_n[DIGITS-1];
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_lz[k] = w_lz[k+1] && (w_hex_n[4*k +: 4] == 4'h0) && !w_dp_n[k];
        end
        w_lz[0] = 1'b0;

        w_nib       = w_hex_n[4*int'(w_idx_n) +: 4];
        w_nib_blank = lz_blank && w_lz[w_idx_n];
        w_nib_dp    = w_dp_n[w_idx_n] && !w_nib_blank;

        w_sel_n = '0;
        if (w_presc_n >= BLANK_LIM) begin
            w_sel_n[w_idx_n] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_act_hex  <= '0;
            r_act_dp   <= '0;
            r_pend_hex <= '0;
            r_pend_dp  <= '0;
            pending    <= 1'b0;
            SEL        <= SEL_IDLE;
            HEX_out    <= 4'h0;
            dp_out     <= 1'b0;
            blank_out  <= 1'b1;
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_presc   <= w_presc_n;
            r_idx     <= w_idx_n;
            r_act_hex <= w_hex_n;
            r_act_dp  <= w_dp_n;
            if (w_frame) begin
                pending <= 1'b0;
            end else if (load) begin
                r_pend_hex <= HEX_data;
                r_pend_dp  <= dp_data;
                pending    <= 1'b1;
            end
            SEL        <= (SEL_ACTIVE_LOW != 0) ? ~w_sel_n : w_sel_n;
            HEX_out    <= w_nib;
            dp_out     <= w_nib_dp;
            blank_out  <= w_nib_blank;
            scan_tick  <= w_tc;
            frame_done <= w_frame;
        end
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner (4 digits, 4-cycle slots, 1-cycle guard, active-low SEL).
module tb_hex_digit_scanner;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] HEX_data;
    logic [3:0]  dp_data;
    logic        load;
    logic        lz_blank;
    logic [3:0]  HEX_out;
    logic        dp_out;
    logic        blank_out;
    logic [3:0]  SEL;
    logic        pending;
    logic        scan_tick;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    hex_digit_scanner #(
        .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK), .RST(RST), .HEX_data(HEX_data), .dp_data(dp_data), .load(load),
        .lz_blank(lz_blank), .HEX_out(HEX_out), .dp_out(dp_out), .blank_out(blank_out),
        .SEL(SEL), .pending(pending), .scan_tick(scan_tick), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slot 0 right after reset: one guard cycle already elapsed, three selected cycles follow.
    task automatic after_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_slot0_sel", 16'(SEL), 16'hE);
            chk("rst_slot0_hex", 16'(HEX_out), 16'h0);
            chk("rst_slot0_blank", 16'(blank_out), 16'h0);
        end
        step();
    endtask

    // Called on the sample point just after the edge that entered 'slot'; returns at the next slot start.
    // load_at: 1 = pulse load in the first cycle of the slot, 2 = in the last cycle.
    task automatic check_slot(input int slot, input logic [3:0] hx, input logic dp, input logic blk,
                              input logic tk, input logic fd, input int load_at,
                              input logic [15:0] ld_hex, input logic [3:0] ld_dp);
        logic [3:0] sel_exp;
        sel_exp = ~(4'b0001 << slot);
        chk("guard_sel", 16'(SEL), 16'hF);
        chk("scan_tick", 16'(scan_tick), 16'(tk));
        chk("frame_done", 16'(frame_done), 16'(fd));
        chk("hex_out", 16'(HEX_out), 16'(hx));
        chk("dp_out", 16'(dp_out), 16'(dp));
        chk("blank_out", 16'(blank_out), 16'(blk));
        if (load_at == 1) begin
            HEX_data = ld_hex;
            dp_data  = ld_dp;
            load     = 1'b1;
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            load = 1'b0;
            chk("active_sel", 16'(SEL), 16'(sel_exp));
            chk("hold_hex", 16'(HEX_out), 16'(hx));
            chk("hold_dp", 16'(dp_out), 16'(dp));
            chk("hold_blank", 16'(blank_out), 16'(blk));
            chk("tick_low", 16'(scan_tick), 16'h0);
            if (i == 1 && load_at == 1) chk("pending_set", 16'(pending), 16'h1);
        end
        if (load_at == 2) begin
            HEX_data = ld_hex;
            dp_data  = ld_dp;
            load     = 1'b1;
        end
        step();
        load = 1'b0;
    endtask

    initial begin
        RST = 1'b1; HEX_data = '0; dp_data = '0; load = 1'b0; lz_blank = 1'b0;

        // Reset hold, with a load that must be dropped
        step();
        HEX_data = 16'h9999; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("rst_sel", 16'(SEL), 16'hF);
        chk("rst_blank", 16'(blank_out), 16'h1);
        chk("rst_hex", 16'(HEX_out), 16'h0);
        chk("rst_dp", 16'(dp_out), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_tick", 16'(scan_tick), 16'h0);
        chk("rst_frame", 16'(frame_done), 16'h0);
        RST = 1'b0;
        after_reset();
        check_slot(1, 4'h0, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h0, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h0, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(0, 4'h0, 0, 0, 1, 1, 0, 16'h0, 4'h0);

        // Mid-frame load stays pending until the boundary
        check_slot(1, 4'h0, 0, 0, 1, 0, 1, 16'h1234, 4'h0);
        check_slot(2, 4'h0, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h0, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        chk("pending_cleared", 16'(pending), 16'h0);
        check_slot(0, 4'h4, 0, 0, 1, 1, 0, 16'h0, 4'h0);
        check_slot(1, 4'h3, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h2, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h1, 0, 0, 1, 0, 0, 16'h0, 4'h0);

        // Two loads in one frame: last wins
        check_slot(0, 4'h4, 0, 0, 1, 1, 1, 16'hAAAA, 4'h0);
        check_slot(1, 4'h3, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h2, 0, 0, 1, 0, 1, 16'h5555, 4'h0);
        check_slot(3, 4'h1, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        chk("pending_cleared2", 16'(pending), 16'h0);

        // Boundary-cycle load overrides pending 1111
        check_slot(0, 4'h5, 0, 0, 1, 1, 0, 16'h0, 4'h0);
        check_slot(1, 4'h5, 0, 0, 1, 0, 1, 16'h1111, 4'h0);
        check_slot(2, 4'h5, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        chk("pending_1111", 16'(pending), 16'h1);
        check_slot(3, 4'h5, 0, 0, 1, 0, 2, 16'hBEEF, 4'h0);
        chk("pending_boundary", 16'(pending), 16'h0);

        // Leading-zero suppression
        lz_blank = 1'b1;
        check_slot(0, 4'hF, 0, 0, 1, 1, 1, 16'h0070, 4'b0000);
        check_slot(1, 4'hE, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'hE, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'hB, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(0, 4'h0, 0, 0, 1, 1, 1, 16'h0070, 4'b0100);
        check_slot(1, 4'h7, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        check_slot(0, 4'h0, 0, 0, 1, 1, 0, 16'h0, 4'h0);
        check_slot(1, 4'h7, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h0, 1, 0, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);

        // Reset mid-scan at slot 2 with pending data
        check_slot(0, 4'h0, 0, 0, 1, 1, 1, 16'h9999, 4'h0);
        check_slot(1, 4'h7, 0, 0, 1, 0, 0, 16'h0, 4'h0);
        chk("pending_before_rst", 16'(pending), 16'h1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_sel", 16'(SEL), 16'hF);
        chk("mid_rst_blank", 16'(blank_out), 16'h1);
        chk("mid_rst_hex", 16'(HEX_out), 16'h0);
        chk("mid_rst_dp", 16'(dp_out), 16'h0);
        chk("mid_rst_pending", 16'(pending), 16'h0);
        chk("mid_rst_tick", 16'(scan_tick), 16'h0);
        after_reset();
        check_slot(1, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        check_slot(2, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        check_slot(3, 4'h0, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        check_slot(0, 4'h0, 0, 0, 1, 1, 0, 16'h0, 4'h0);
        chk("final_pending", 16'(pending), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
